jk_bank_ctrl: RTL and testbench

JK_BANK_CTRL -- requirements
Module: jk_bank_ctrl

---
 rtl/jk_bank_ctrl.sv | 151 +++++++++++++++
 tb/tb_jk_bank_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/jk_bank_ctrl.sv
// jk_bank_ctrl: two-requester round-robin controller that drives a JK flip-flop
// bank. Each granted operation produces one DRIVE cycle with registered J/K,
// then SETTLE idle cycles. A shadow copy of the bank state is kept in Q/QN.
module jk_bank_ctrl #(
    parameter int WIDTH  = 8,
    parameter int SETTLE = 2
) (
    input  logic             CLK,
    input  logic             RN,
    input  logic             REQ0,
    input  logic             REQ1,
    input  logic [1:0]       OP0,
    input  logic [1:0]       OP1,
    input  logic [WIDTH-1:0] MASK0,
    input  logic [WIDTH-1:0] MASK1,
    output logic             GNT0,
    output logic             GNT1,
    output logic [WIDTH-1:0] J,
    output logic [WIDTH-1:0] K,
    output logic             BUSY,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] QN
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRIVE  = 2'd1,
        ST_SETTLE = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        OP_HOLD   = 2'b00,
        OP_SET    = 2'b01,
        OP_CLEAR  = 2'b10,
        OP_TOGGLE = 2'b11
    } op_e;

    // Counter value loaded on entering SETTLE; counts down to zero.
    localparam logic [3:0] SETTLE_LAST = 4'((SETTLE == 0) ? 0 : SETTLE - 1);

    state_e           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             prio_q, prio_d;   // 0: REQ0 wins a tie, 1: REQ1 wins a tie
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] j_q, j_d;
    logic [WIDTH-1:0] k_q, k_d;
    logic             gnt0_q, gnt0_d;
    logic             gnt1_q, gnt1_d;

    logic             any_req;
    logic             win1;
    logic [1:0]       sel_op;
    logic [WIDTH-1:0] sel_mask;

    // Arbitration: a lone request always wins, a tie goes to the priority pointer.
    always_comb begin
        any_req  = REQ0 | REQ1;
        win1     = REQ1 & (~REQ0 | prio_q);
        sel_op   = win1 ? OP1 : OP0;
        sel_mask = win1 ? MASK1 : MASK0;
    end

    // State register; reset aborts any operation in flight with no Q update.
    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            prio_q  <= 1'b0;
            q_q     <= '0;
            j_q     <= '0;
            k_q     <= '0;
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples pre-edge values regardless of statement order.
            state_q <= state_d;
            cnt_q   <= cnt_d;
            prio_q  <= prio_d;
            q_q     <= q_d;
            j_q     <= j_d;
            k_q     <= k_d;
            gnt0_q  <= gnt0_d;
            gnt1_q  <= gnt1_d;
        end
    end

    // Next-state logic: sequencing, priority hand-over and the shadow bank update.
    always_comb begin
        // NOTE: defaults first so every path assigns every signal and no latch is inferred.
        state_d = state_q;
        cnt_d   = cnt_q;
        prio_d  = prio_q;
        q_d     = q_q;
        unique case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    state_d = ST_DRIVE;
                    prio_d  = ~win1;
                end
            end
            ST_DRIVE: begin
                q_d = (j_q & ~q_q) | (~k_q & q_q);
                if (SETTLE == 0) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_SETTLE;
                    cnt_d   = SETTLE_LAST;
                end
            end
            ST_SETTLE: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output logic: grant pulse and J/K drive are loaded on the edge entering DRIVE
    // and fall back to zero on every other edge.
    always_comb begin
        gnt0_d = 1'b0;
        gnt1_d = 1'b0;
        j_d    = '0;
        k_d    = '0;
        if (state_q == ST_IDLE && any_req) begin
            gnt0_d = ~win1;
            gnt1_d = win1;
            unique case (op_e'(sel_op))
                OP_SET:    j_d = sel_mask;
                OP_CLEAR:  k_d = sel_mask;
                OP_TOGGLE: begin
                    j_d = sel_mask;
                    k_d = sel_mask;
                end
                default: ;
            endcase
        end
    end

    assign GNT0 = gnt0_q;
    assign GNT1 = gnt1_q;
    assign J    = j_q;
    assign K    = k_q;
    assign BUSY = (state_q != ST_IDLE);
    assign Q    = q_q;
    assign QN   = ~q_q;

endmodule

// File: tb/tb_jk_bank_ctrl.sv
// Bench for jk_bank_ctrl: two instances (SETTLE=2 and SETTLE=0) share the same
// stimulus; an operation-level model predicts every output of both each cycle,
// and directed literal checks pin the model to hand-computed values.
module tb_jk_bank_ctrl;

    localparam int W = 8;
    localparam int ST [2] = '{2, 0};

    logic         CLK = 1'b0;
    logic         RN  = 1'b1;
    logic         REQ0 = 1'b0, REQ1 = 1'b0;
    logic [1:0]   OP0 = 2'b00, OP1 = 2'b00;
    logic [W-1:0] MASK0 = '0, MASK1 = '0;

    logic         d_g0 [2];
    logic         d_g1 [2];
    logic [W-1:0] d_j  [2];
    logic [W-1:0] d_k  [2];
    logic         d_busy [2];
    logic [W-1:0] d_q  [2];
    logic [W-1:0] d_qn [2];

    int n_checks = 0;
    int n_errors = 0;

    always #5 CLK = ~CLK;

    jk_bank_ctrl #(.WIDTH(W), .SETTLE(2)) dut_s2 (
        .CLK(CLK), .RN(RN), .REQ0(REQ0), .REQ1(REQ1), .OP0(OP0), .OP1(OP1),
        .MASK0(MASK0), .MASK1(MASK1), .GNT0(d_g0[0]), .GNT1(d_g1[0]),
        .J(d_j[0]), .K(d_k[0]), .BUSY(d_busy[0]), .Q(d_q[0]), .QN(d_qn[0]));

    jk_bank_ctrl #(.WIDTH(W), .SETTLE(0)) dut_s0 (
        .CLK(CLK), .RN(RN), .REQ0(REQ0), .REQ1(REQ1), .OP0(OP0), .OP1(OP1),
        .MASK0(MASK0), .MASK1(MASK1), .GNT0(d_g0[1]), .GNT1(d_g1[1]),
        .J(d_j[1]), .K(d_k[1]), .BUSY(d_busy[1]), .Q(d_q[1]), .QN(d_qn[1]));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- operation-level model ----------------
    logic [W-1:0] m_q [2];
    logic [W-1:0] m_j [2];
    logic [W-1:0] m_k [2];
    logic [W-1:0] m_mask [2];
    logic [1:0]   m_op [2];
    logic         m_g0 [2];
    logic         m_g1 [2];
    logic         m_drv [2];
    logic         m_prio1 [2];
    int           m_left [2];   // cycles of busyness still to come after this edge

    function automatic logic [W-1:0] apply_op(input logic [1:0] op, input logic [W-1:0] m,
                                              input logic [W-1:0] q);
        case (op)
            2'b01:   return q | m;
            2'b10:   return q & ~m;
            2'b11:   return q ^ m;
            default: return q;
        endcase
    endfunction

    always @(posedge CLK or negedge RN) begin
        for (int i = 0; i < 2; i++) begin
            if (!RN) begin
                m_q[i] = '0; m_j[i] = '0; m_k[i] = '0; m_mask[i] = '0; m_op[i] = 2'b00;
                m_g0[i] = 1'b0; m_g1[i] = 1'b0; m_drv[i] = 1'b0; m_prio1[i] = 1'b0;
                m_left[i] = 0;
            end else begin
                if (m_drv[i]) m_q[i] = apply_op(m_op[i], m_mask[i], m_q[i]);
                m_drv[i] = 1'b0; m_g0[i] = 1'b0; m_g1[i] = 1'b0; m_j[i] = '0; m_k[i] = '0;
                if (m_left[i] > 0) begin
                    m_left[i]--;
                end else if (REQ0 || REQ1) begin
                    logic take1;
                    take1 = REQ1 && (!REQ0 || m_prio1[i]);
                    m_g0[i]    = !take1;
                    m_g1[i]    = take1;
                    m_op[i]    = take1 ? OP1 : OP0;
                    m_mask[i]  = take1 ? MASK1 : MASK0;
                    m_prio1[i] = !take1;
                    m_drv[i]   = 1'b1;
                    m_left[i]  = ST[i] + 1;
                    m_j[i] = (m_op[i] == 2'b01 || m_op[i] == 2'b11) ? m_mask[i] : '0;
                    m_k[i] = (m_op[i] == 2'b10 || m_op[i] == 2'b11) ? m_mask[i] : '0;
                end
            end
        end
    end

    // Compare every output of both instances against the model each cycle.
    always @(negedge CLK) begin
        if (RN) begin
            for (int i = 0; i < 2; i++) begin
                logic [W-1:0] exp_qn;
                exp_qn = ~m_q[i];
                check($sformatf("i%0d_gnt0", i), 32'(d_g0[i]), 32'(m_g0[i]));
                check($sformatf("i%0d_gnt1", i), 32'(d_g1[i]), 32'(m_g1[i]));
                check($sformatf("i%0d_j", i), 32'(d_j[i]), 32'(m_j[i]));
                check($sformatf("i%0d_k", i), 32'(d_k[i]), 32'(m_k[i]));
                check($sformatf("i%0d_busy", i), 32'(d_busy[i]), 32'(m_left[i] > 0));
                check($sformatf("i%0d_q", i), 32'(d_q[i]), 32'(m_q[i]));
                check($sformatf("i%0d_qn", i), 32'(d_qn[i]), 32'(exp_qn));
            end
        end
    end

    task automatic tick();
        @(negedge CLK);
    endtask

    task automatic check_reset_values(input string tag);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("%s_i%0d_gnt0", tag, i), 32'(d_g0[i]), 32'd0);
            check($sformatf("%s_i%0d_gnt1", tag, i), 32'(d_g1[i]), 32'd0);
            check($sformatf("%s_i%0d_j", tag, i), 32'(d_j[i]), 32'h00);
            check($sformatf("%s_i%0d_k", tag, i), 32'(d_k[i]), 32'h00);
            check($sformatf("%s_i%0d_busy", tag, i), 32'(d_busy[i]), 32'd0);
            check($sformatf("%s_i%0d_q", tag, i), 32'(d_q[i]), 32'h00);
            check($sformatf("%s_i%0d_qn", tag, i), 32'(d_qn[i]), 32'hFF);
        end
    endtask

    // Watchdog: the directed sequence is fixed-length, this only guards a stuck clock.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int busy_cycles;

        // Reset takes effect without a clock edge.
        #1 RN = 1'b0;
        #1 check_reset_values("rst");
        tick(); tick();
        RN = 1'b1;

        // Set 0x0F from requester 0.
        REQ0 = 1'b1; OP0 = 2'b01; MASK0 = 8'h0F;
        tick();
        check("set_gnt0", 32'(d_g0[0]), 32'd1);
        check("set_gnt1", 32'(d_g1[0]), 32'd0);
        check("set_j", 32'(d_j[0]), 32'h0F);
        check("set_k", 32'(d_k[0]), 32'h00);
        check("set_q_not_yet", 32'(d_q[0]), 32'h00);
        busy_cycles = int'(d_busy[0]);
        REQ0 = 1'b0;
        tick();
        check("set_q", 32'(d_q[0]), 32'h0F);
        check("set_qn", 32'(d_qn[0]), 32'hF0);
        check("set_gnt0_pulse", 32'(d_g0[0]), 32'd0);
        busy_cycles += int'(d_busy[0]);
        tick(); busy_cycles += int'(d_busy[0]);
        tick(); busy_cycles += int'(d_busy[0]);
        check("set_busy_cycles", 32'(busy_cycles), 32'd3);

        // Toggle all bits from requester 1.
        REQ1 = 1'b1; OP1 = 2'b11; MASK1 = 8'hFF;
        tick();
        check("tog_gnt1", 32'(d_g1[0]), 32'd1);
        check("tog_j", 32'(d_j[0]), 32'hFF);
        check("tog_k", 32'(d_k[0]), 32'hFF);
        REQ1 = 1'b0;
        tick();
        check("tog_q", 32'(d_q[0]), 32'hF0);
        check("tog_jk_off", 32'({d_j[0], d_k[0]}), 32'h0000);
        tick(); tick();

        // Both requesters held: GNT0, GNT1 four cycles later, then GNT0 again.
        REQ0 = 1'b1; OP0 = 2'b01; MASK0 = 8'h01;
        REQ1 = 1'b1; OP1 = 2'b10; MASK1 = 8'h10;
        for (int k = 1; k <= 9; k++) begin
            tick();
            check($sformatf("rr_gnt0_k%0d", k), 32'(d_g0[0]), 32'(k == 1 || k == 9));
            check($sformatf("rr_gnt1_k%0d", k), 32'(d_g1[0]), 32'(k == 5));
        end
        REQ0 = 1'b0; REQ1 = 1'b0;
        tick(); tick(); tick(); tick();
        check("rr_q", 32'(d_q[0]), 32'hE1);

        // Hold operation: grant but no J/K and no Q change.
        REQ1 = 1'b1; OP1 = 2'b00; MASK1 = 8'hAA;
        tick();
        check("hold_gnt1", 32'(d_g1[0]), 32'd1);
        check("hold_jk", 32'({d_j[0], d_k[0]}), 32'h0000);
        REQ1 = 1'b0;
        tick();
        check("hold_q", 32'(d_q[0]), 32'hE1);
        tick(); tick();

        // Fill to 0xFF, then clear 0x81 and reset during SETTLE.
        REQ0 = 1'b1; OP0 = 2'b01; MASK0 = 8'hFF;
        tick(); REQ0 = 1'b0;
        tick();
        check("fill_q", 32'(d_q[0]), 32'hFF);
        tick(); tick();
        REQ0 = 1'b1; OP0 = 2'b10; MASK0 = 8'h81;
        tick(); REQ0 = 1'b0;
        tick();
        check("clr_q", 32'(d_q[0]), 32'h7E);
        check("clr_busy_settle", 32'(d_busy[0]), 32'd1);
        #2 RN = 1'b0;
        #1 check_reset_values("abort");

        // Request present across reset release: first edge is an ordinary IDLE evaluation.
        REQ0 = 1'b1; OP0 = 2'b11; MASK0 = 8'h01;
        #1 RN = 1'b1;
        tick();
        check("rel_s2_gnt0", 32'(d_g0[0]), 32'd1);
        check("rel_s0_gnt0", 32'(d_g0[1]), 32'd1);

        // SETTLE=0 instance: REQ0 held, grant every 2 cycles, Q[0] toggles per grant.
        for (int k = 1; k <= 8; k++) begin
            logic [W-1:0] qv;
            tick();
            qv = d_q[1];
            check($sformatf("s0_gnt0_k%0d", k), 32'(d_g0[1]), 32'(k % 2 == 0));
            check($sformatf("s0_q0_k%0d", k), 32'(qv[0]), 32'(((k + 1) / 2) % 2));
        end
        REQ0 = 1'b0;
        tick(); tick(); tick(); tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
